sram_access_scheduler: RTL and testbench

- Top-level sequencer and owner-mux for the single external SRAM port.
- Runs the decode pipeline in order: UART image load, milestone 1, milestone 2, then VGA display.
- Grants SRAM address/data/we_n to exactly one requester per phase, with a forced-idle turnaround cycle between owners.
- Issues start pulses to the milestone blocks and collects their done pulses; sits between the UART/M1/M2/VGA units and SRAM_controller.

---
 rtl/sram_access_scheduler_pkg.sv | 19 +
 rtl/sram_owner_mux.sv | 52 +++++
 rtl/sram_access_scheduler.sv | 157 +++++++++++++++
 tb/tb_sram_access_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_access_scheduler_pkg.sv
// Shared state encoding and default timing constants for the SRAM access scheduler.
package sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_UART_RX = 4'd1,
    S_GAP_M1  = 4'd2,
    S_M1      = 4'd3,
    S_GAP_M2  = 4'd4,
    S_M2      = 4'd5,
    S_GAP_VGA = 4'd6,
    S_ERROR   = 4'd7
  } sched_state_t;

  // 1 s of line silence at 50 MHz ends an image load.
  localparam logic [25:0] UART_TIMEOUT_DEFAULT = 26'd49999999;
  localparam logic [31:0] WDOG_CYCLES_DEFAULT  = 32'd100000000;

endpackage

// File: rtl/sram_owner_mux.sv
// Combinational selection of the single SRAM requester owning the port in each scheduler state.
module sram_owner_mux
  import sched_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  sched_state_t      state,
  input  logic [ADDR_W-1:0] uart_address,
  input  logic [DATA_W-1:0] uart_write_data,
  input  logic              uart_we_n,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_write_data,
  input  logic              m1_we_n,
  input  logic [ADDR_W-1:0] m2_address,
  input  logic [DATA_W-1:0] m2_write_data,
  input  logic              m2_we_n,
  input  logic [ADDR_W-1:0] vga_address,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  output logic              sram_we_n
);

  // Gap and error states park the port on a harmless read of address 0.
  always_comb begin
    sram_address    = '0;
    sram_write_data = '0;
    sram_we_n       = 1'b1;
    case (state)
      S_IDLE: begin
        sram_address = vga_address;
      end
      S_UART_RX: begin
        sram_address    = uart_address;
        sram_write_data = uart_write_data;
        sram_we_n       = uart_we_n;
      end
      S_M1: begin
        sram_address    = m1_address;
        sram_write_data = m1_write_data;
        sram_we_n       = m1_we_n;
      end
      S_M2: begin
        sram_address    = m2_address;
        sram_write_data = m2_write_data;
        sram_we_n       = m2_we_n;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_access_scheduler.sv
// Sequences UART load -> M1 -> M2 -> VGA and hands the SRAM port to one owner at a time.
// Optional milestone watchdog and S_ERROR recovery enabled by defining SCHED_WATCHDOG_EN.
module sram_access_scheduler
  import sched_pkg::*;
#(
  parameter logic [25:0] UART_TIMEOUT = UART_TIMEOUT_DEFAULT,
  parameter logic [31:0] WDOG_CYCLES  = WDOG_CYCLES_DEFAULT,
  parameter int          ADDR_W       = 18,
  parameter int          DATA_W       = 16
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic              UART_RX_I,
  input  logic              rerun_req,
  input  logic [ADDR_W-1:0] UART_SRAM_address,
  input  logic [DATA_W-1:0] UART_SRAM_write_data,
  input  logic              UART_SRAM_we_n,
  input  logic [ADDR_W-1:0] M1_SRAM_address,
  input  logic [DATA_W-1:0] M1_SRAM_write_data,
  input  logic              M1_SRAM_we_n,
  input  logic [ADDR_W-1:0] M2_SRAM_address,
  input  logic [DATA_W-1:0] M2_SRAM_write_data,
  input  logic              M2_SRAM_we_n,
  input  logic [ADDR_W-1:0] VGA_SRAM_address,
  input  logic              M1_done,
  input  logic              M2_done,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [DATA_W-1:0] SRAM_write_data,
  output logic              SRAM_we_n,
  output logic              UART_rx_initialize,
  output logic              UART_rx_enable,
  output logic              VGA_enable,
  output logic              M1_start,
  output logic              M2_start,
  output logic [3:0]        sched_state,
  output logic              wdog_error
);

  sched_state_t state, state_next;
  logic         uart_init;
  logic [25:0]  uart_timer;
  logic         wdog_hit;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      uart_init  <= 1'b0;
      uart_timer <= '0;
    end else begin
      state     <= state_next;
      uart_init <= (state == S_IDLE) && (state_next == S_UART_RX);
      // Any UART write restarts the silence timer; it holds at all-ones rather than wrapping.
      if ((state != S_UART_RX) || !UART_SRAM_we_n)
        uart_timer <= '0;
      else if (uart_timer != '1)
        uart_timer <= uart_timer + 26'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!UART_RX_I)
          state_next = S_UART_RX;
        else if (rerun_req)
          state_next = S_GAP_M1;
      end
      S_UART_RX: begin
        if (uart_timer >= UART_TIMEOUT)
          state_next = S_GAP_M1;
      end
      S_GAP_M1:  state_next = S_M1;
      S_M1: begin
        if (M1_done)
          state_next = S_GAP_M2;
        else if (wdog_hit)
          state_next = S_ERROR;
      end
      S_GAP_M2:  state_next = S_M2;
      S_M2: begin
        if (M2_done)
          state_next = S_GAP_VGA;
        else if (wdog_hit)
          state_next = S_ERROR;
      end
      S_GAP_VGA: state_next = S_IDLE;
`ifdef SCHED_WATCHDOG_EN
      S_ERROR: begin
        if (rerun_req)
          state_next = S_GAP_M1;
      end
`endif
      default:   state_next = S_IDLE;
    endcase
  end

`ifdef SCHED_WATCHDOG_EN
  logic [31:0] wdog_cnt;
  logic        wdog_flag;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt  <= '0;
      wdog_flag <= 1'b0;
    end else begin
      if ((state == S_M1) || (state == S_M2)) begin
        if (wdog_cnt != '1)
          wdog_cnt <= wdog_cnt + 32'd1;
      end else begin
        wdog_cnt <= '0;
      end
      if ((state_next == S_ERROR) && (state != S_ERROR))
        wdog_flag <= 1'b1;
      else if ((state == S_ERROR) && rerun_req)
        wdog_flag <= 1'b0;
    end
  end

  // Counter reads N-1 in the Nth owned cycle, so the owner keeps SRAM for exactly WDOG_CYCLES.
  assign wdog_hit   = (wdog_cnt >= (WDOG_CYCLES - 32'd1));
  assign wdog_error = wdog_flag;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_hit    = 1'b0;
  assign wdog_error  = 1'b0;
`endif

  assign UART_rx_initialize = uart_init;
  assign UART_rx_enable     = (state == S_UART_RX) && !uart_init;
  assign VGA_enable         = (state == S_IDLE);
  assign M1_start           = (state == S_GAP_M1);
  assign M2_start           = (state == S_GAP_M2);
  assign sched_state        = state;

  sram_owner_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_owner_mux (
    .state           (state),
    .uart_address    (UART_SRAM_address),
    .uart_write_data (UART_SRAM_write_data),
    .uart_we_n       (UART_SRAM_we_n),
    .m1_address      (M1_SRAM_address),
    .m1_write_data   (M1_SRAM_write_data),
    .m1_we_n         (M1_SRAM_we_n),
    .m2_address      (M2_SRAM_address),
    .m2_write_data   (M2_SRAM_write_data),
    .m2_we_n         (M2_SRAM_we_n),
    .vga_address     (VGA_SRAM_address),
    .sram_address    (SRAM_address),
    .sram_write_data (SRAM_write_data),
    .sram_we_n       (SRAM_we_n)
  );

endmodule

// File: tb/tb_sram_access_scheduler.sv
// Randomized bench: stimulus predicts state timeline from phase rules; a negedge monitor checks it.
`timescale 1ns/1ps
module tb_sram_access_scheduler;
  import sched_pkg::*;

  localparam int          AW   = 18;
  localparam int          DW   = 16;
  localparam logic [25:0] TMO  = 26'd100;
  localparam logic [31:0] WDOG = 32'd50;
`ifdef SCHED_WATCHDOG_EN
  localparam int MAX_LAT = 40;
`else
  localparam int MAX_LAT = 600;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          uart_rx = 1'b1;
  logic          rerun = 1'b0;
  logic [AW-1:0] uart_a = '0, m1_a = '0, m2_a = '0, vga_a = '0;
  logic [DW-1:0] uart_d = '0, m1_d = '0, m2_d = '0;
  logic          uart_we = 1'b1, m1_we = 1'b1, m2_we = 1'b1;
  logic          m1_done = 1'b0, m2_done = 1'b0;

  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic          sram_we, rx_init, rx_en, vga_en, m1_start, m2_start, wdog_err;
  logic [3:0]    st;

  sram_access_scheduler #(
    .UART_TIMEOUT (TMO),
    .WDOG_CYCLES  (WDOG),
    .ADDR_W       (AW),
    .DATA_W       (DW)
  ) dut (
    .CLOCK_50_I           (clk),
    .resetn               (resetn),
    .UART_RX_I            (uart_rx),
    .rerun_req            (rerun),
    .UART_SRAM_address    (uart_a),
    .UART_SRAM_write_data (uart_d),
    .UART_SRAM_we_n       (uart_we),
    .M1_SRAM_address      (m1_a),
    .M1_SRAM_write_data   (m1_d),
    .M1_SRAM_we_n         (m1_we),
    .M2_SRAM_address      (m2_a),
    .M2_SRAM_write_data   (m2_d),
    .M2_SRAM_we_n         (m2_we),
    .VGA_SRAM_address     (vga_a),
    .M1_done              (m1_done),
    .M2_done              (m2_done),
    .SRAM_address         (sram_a),
    .SRAM_write_data      (sram_d),
    .SRAM_we_n            (sram_we),
    .UART_rx_initialize   (rx_init),
    .UART_rx_enable       (rx_en),
    .VGA_enable           (vga_en),
    .M1_start             (m1_start),
    .M2_start             (m2_start),
    .sched_state          (st),
    .wdog_error           (wdog_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    sched_state_t st;
    logic         init;
    logic         wd;
  } exp_t;

  exp_t         exp_q[$];
  int           ntests = 0;
  int           nfail = 0;
  sched_state_t mdl_state = S_IDLE;
  exp_t         mon_e;
  bit           mon_hit;
  int           m_entry;
  int           guard;

  task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, c, act, req);
    end
  endtask

  // Keep the queue ordered by cycle so the monitor can consume it front-first.
  task automatic expect_at(int c, sched_state_t s, logic init, logic wd);
    exp_t e;
    int   i;
    e.cyc = c; e.st = s; e.init = init; e.wd = wd;
    i = exp_q.size();
    while (i > 0 && exp_q[i-1].cyc > c) i--;
    exp_q.insert(i, e);
  endtask

  task automatic check_sample(exp_t e);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    ea = '0; ed = '0; ew = 1'b1;
    case (e.st)
      S_IDLE:    ea = vga_a;
      S_UART_RX: begin ea = uart_a; ed = uart_d; ew = uart_we; end
      S_M1:      begin ea = m1_a;   ed = m1_d;   ew = m1_we;   end
      S_M2:      begin ea = m2_a;   ed = m2_d;   ew = m2_we;   end
      default:   ;
    endcase
    chk("state",      cyc, 32'(st),       32'(e.st));
    chk("sram_addr",  cyc, 32'(sram_a),   32'(ea));
    chk("sram_data",  cyc, 32'(sram_d),   32'(ed));
    chk("sram_we_n",  cyc, 32'(sram_we),  32'(ew));
    chk("vga_enable", cyc, 32'(vga_en),   32'(e.st == S_IDLE));
    chk("m1_start",   cyc, 32'(m1_start), 32'(e.st == S_GAP_M1));
    chk("m2_start",   cyc, 32'(m2_start), 32'(e.st == S_GAP_M2));
    chk("rx_init",    cyc, 32'(rx_init),  32'(e.init));
    chk("rx_enable",  cyc, 32'(rx_en),    32'(e.st == S_UART_RX && !e.init));
    chk("wdog_error", cyc, 32'(wdog_err), 32'(e.wd));
  endtask

  always @(negedge clk) begin
    mon_hit = 1'b0;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      ntests++;
      nfail++;
      $display("FAIL missed_sample cyc=%0d got=none expected_state=%0d", mon_e.cyc, mon_e.st);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      mdl_state = mon_e.st;
      mon_hit = 1'b1;
      check_sample(mon_e);
    end
    if (!mon_hit) chk("state_hold", cyc, 32'(st), 32'(mdl_state));
  end

  // Requester buses carry fresh random traffic every cycle; UART we_n stays under stimulus control.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      uart_a = AW'($urandom); uart_d = DW'($urandom);
      m1_a   = AW'($urandom); m1_d   = DW'($urandom); m1_we = 1'($urandom_range(0, 1));
      m2_a   = AW'($urandom); m2_d   = DW'($urandom); m2_we = 1'($urandom_range(0, 1));
      vga_a  = AW'($urandom);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(int t);
    while (cyc < t) step();
  endtask

  // Load ends TMO+1 cycles after the last write (or after entry if none), then one gap cycle.
  task automatic uart_phase(bit with_rerun, output int m);
    int e, last, n, w;
    uart_rx = 1'b0;
    rerun   = with_rerun;
    expect_at(cyc, S_IDLE, 1'b0, 1'b0);
    e = cyc + 1;
    expect_at(e, S_UART_RX, 1'b1, 1'b0);
    expect_at(e + 1, S_UART_RX, 1'b0, 1'b0);
    step();
    uart_rx = 1'b1;
    rerun   = 1'b0;
    last = e;
    n = $urandom_range(0, 3);
    for (int k = 0; k < n; k++) begin
      goto_cyc(last + $urandom_range(5, 90));
      uart_we = 1'b0;
      w = cyc;
      expect_at(w, S_UART_RX, 1'b0, 1'b0);
      step();
      uart_we = 1'b1;
      last = w + 1;
    end
    expect_at(last + int'(TMO) + 1, S_GAP_M1, 1'b0, 1'b0);
    m = last + int'(TMO) + 2;
    expect_at(m, S_M1, 1'b0, 1'b0);
  endtask

  task automatic rerun_phase(output int m);
    rerun = 1'b1;
    expect_at(cyc, S_IDLE, 1'b0, 1'b0);
    expect_at(cyc + 1, S_GAP_M1, 1'b0, 1'b0);
    m = cyc + 2;
    expect_at(m, S_M1, 1'b0, 1'b0);
    step();
    rerun = 1'b0;
  endtask

  task automatic milestones(int m, bit do_reset);
    int d1, d2, s, m2e, r, idle;
    // done coincident with M1_start is ignored
    goto_cyc(m - 1);
    m1_done = 1'b1;
    step();
    m1_done = 1'b0;
    d1 = $urandom_range(1, MAX_LAT);
    // stray M2_done and rerun_req while M1 owns SRAM
    s = m + $urandom_range(0, d1 - 1);
    expect_at(s, S_M1, 1'b0, 1'b0);
    goto_cyc(s);
    m2_done = 1'b1;
    rerun   = 1'b1;
    step();
    m2_done = 1'b0;
    rerun   = 1'b0;
    goto_cyc(m + d1);
    expect_at(m + d1 + 1, S_GAP_M2, 1'b0, 1'b0);
    m2e = m + d1 + 2;
    expect_at(m2e, S_M2, 1'b0, 1'b0);
    m1_done = 1'b1;
    step();
    m1_done = 1'b0;
    m2_done = 1'b1;
    step();
    m2_done = 1'b0;
    d2 = $urandom_range(1, MAX_LAT);
    if (do_reset) begin
      goto_cyc(m2e + $urandom_range(0, d2));
      resetn = 1'b0;
      r = cyc;
      for (int k = 0; k < 6; k++) expect_at(r + k, S_IDLE, 1'b0, 1'b0);
      repeat (3) step();
      resetn = 1'b1;
      goto_cyc(r + 6);
    end else begin
      expect_at(m2e + $urandom_range(0, d2), S_M2, 1'b0, 1'b0);
      expect_at(m2e + d2 + 1, S_GAP_VGA, 1'b0, 1'b0);
      idle = m2e + d2 + 2;
      expect_at(idle, S_IDLE, 1'b0, 1'b0);
      goto_cyc(m2e + d2);
      m2_done = 1'b1;
      step();
      m2_done = 1'b0;
      goto_cyc(idle);
      m1_done = 1'b1;
      step();
      m1_done = 1'b0;
      goto_cyc(idle + $urandom_range(2, 6));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    resetn = 1'b0;
    repeat (3) step();
    expect_at(cyc, S_IDLE, 1'b0, 1'b0);
    resetn = 1'b1;
    expect_at(cyc + 1, S_IDLE, 1'b0, 1'b0);
    goto_cyc(10);
    for (int it = 0; it < 6; it++) begin
      if (it == 0 || (it != 1 && $urandom_range(0, 1) == 1))
        uart_phase(it == 0 ? 1'b1 : 1'($urandom_range(0, 1)), m_entry);
      else
        rerun_phase(m_entry);
      milestones(m_entry, it == 5);
    end
`ifdef SCHED_WATCHDOG_EN
    rerun_phase(m_entry);
    expect_at(m_entry + int'(WDOG) - 1, S_M1, 1'b0, 1'b0);
    expect_at(m_entry + int'(WDOG), S_ERROR, 1'b0, 1'b1);
    goto_cyc(m_entry + int'(WDOG) + 5);
    expect_at(cyc, S_ERROR, 1'b0, 1'b1);
    expect_at(cyc + 1, S_GAP_M1, 1'b0, 1'b0);
    m_entry = cyc + 2;
    expect_at(m_entry, S_M1, 1'b0, 1'b0);
    rerun = 1'b1;
    step();
    rerun = 1'b0;
    milestones(m_entry, 1'b0);
`endif
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      step();
      guard++;
    end
    chk("queue_drained", cyc, 32'(exp_q.size()), 32'd0);
    step();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
